mcu_link_router: RTL and testbench
==================================

// Module: mcu_link_router
// PURPOSE
//  Shares the single MCU byte link (SPI-derived strobe/start/data) between up to 8
//  byte-level targets: sysctrl, hid, sdc, osd, and so on.
//  - First byte of every frame selects the target. Remaining bytes are forwarded to that target.
//  - Selected target's reply byte is returned to the MCU.
//  - Aggregates per-target interrupt requests into one active-low MCU interrupt line, under an MCU-writable enable mask.
//  - Aborts stalled frames with a watchdog.
// PARAMETERS
//  N_TGT        4      number of targets, 1..8; valid target ids are 0..N_TGT-1
//  TIMEOUT_CYC  65535  clk cycles without in_strobe before an open frame is aborted (>=2)
//  CFG_ID       8'hFE  target id reserved for the router's own config (interrupt enable)
// PORTS
//  clk          in   1        clock
//  reset        in   1        synchronous, active-high
//  in_strobe    in   1        one-cycle pulse: in_data is a valid MCU byte
//  in_start     in   1        qualifies in_strobe: byte is the first byte of a frame
//  in_data      in   8        MCU byte
//  out_data     out  8        reply byte to MCU (registered)
//  tgt_strobe   out  N_TGT    per-target byte strobe (registered, one-hot or zero)
//  tgt_start    out  N_TGT    per-target first-byte flag; only ever high together with tgt_strobe
//  tgt_data     out  8        byte forwarded to targets (shared bus)
//  tgt_dout     in   8*N_TGT  target reply bytes; target k occupies [8k+7:8k]
//  tgt_int      in   N_TGT    per-target interrupt requests (level)
//  int_out_n    out  1        MCU interrupt, low when any enabled tgt_int is high
//  frame_active out  1        high in HDR, ROUTE, CFG or DISCARD
//  timeout_evt  out  1        one-cycle pulse when the watchdog aborts a frame
//  err_cnt      out  8        saturating count of frames opened with an unknown id
// BEHAVIOUR
//  Reset values:
//   - State IDLE; sel 0; wd counter 0; err_cnt 0; int_en all ones.
//   - out_data 8'h00; tgt_strobe 0; tgt_start 0; tgt_data 8'h00; timeout_evt 0.
//  States, entered on in_strobe:
//   - in_start=1 from any state (mid-frame included) always restarts the frame.
//     Latch id=in_data; next state:
//     - id<N_TGT -> HDR, sel=id
//     - id==CFG_ID -> CFG
//     - otherwise -> DISCARD, err_cnt+1 (saturating at 255)
//   - HDR, in_start=0:
//     - tgt_start[sel]=1, tgt_strobe[sel]=1, tgt_data=in_data (target command byte)
//     - go to ROUTE
//   - ROUTE, in_start=0: tgt_strobe[sel]=1, tgt_data=in_data; stay in ROUTE.
//   - CFG, in_start=0: first byte sets int_en=in_data[N_TGT-1:0]; later bytes ignored; stay in CFG.
//   - DISCARD / IDLE, in_start=0: byte dropped, no target strobes.
//  Latency and outputs:
//   - tgt_strobe, tgt_start and tgt_data are registered one cycle after in_strobe.
//     They are single-cycle pulses; all zero when no strobe.
//   - out_data is updated every cycle from current state:
//     - IDLE -> 8'h00
//     - HDR or CFG -> zero-extended (tgt_int & int_en), so the MCU's 2nd byte reads the pending mask
//     - ROUTE -> tgt_dout[sel]
//     - DISCARD -> 8'hFF
//  Watchdog:
//   - Counter clears on every in_strobe and in IDLE; otherwise increments.
//   - At TIMEOUT_CYC-1 in any non-IDLE state: go to IDLE, pulse timeout_evt, clear counter.
//   - No target strobe is generated on abort.
//   - in_strobe on the same cycle as expiry wins: byte is processed, no timeout.
//  Interrupts:
//   - int_out_n = ~|(tgt_int & int_en), combinational.
//   - int_en persists across frames; only reset and CFG frames change it.
//  in_start without in_strobe is ignored. Bits of tgt_* at index >= N_TGT do not exist.
// TESTING
//  - Frames {S:01, 05, AA, 55}, N_TGT=4: tgt_start[1] with data 05, then tgt_strobe[1] with AA, then 55.
//    tgt_dout[1]=3C -> out_data=3C in ROUTE. No strobes on targets 0, 2, 3.
//  - Start byte 07: DISCARD, err_cnt=1, out_data=FF, later bytes produce no strobes.
//    Repeat 300 times -> err_cnt=255.
//  - tgt_int=4'b0110 with frame {S:FE, 04}: int_out_n low before the CFG byte, still low after (bit 2 enabled).
//    Then {S:FE, 00}: int_out_n=1. HDR reply on the next frame = 00.
//  - TIMEOUT_CYC=16, frame {S:02, 11} then idle 16 cycles: timeout_evt pulses once, frame_active=0.
//    Next non-start byte is dropped.
//  - {S:00, 01, 02}, then {S:03, 09} with no gap: tgt_start[3] with 09; target 0 gets no further strobes.
//  - Assert reset mid-ROUTE: all outputs return to reset values next cycle, int_en=all ones.

Source files
------------

// File: rtl/mcu_link_router.sv
// Routes MCU link frames to one of N_TGT byte targets chosen by the first byte.
// Latency: target strobes/data and out_data are registered, one cycle after the cause.
// No backpressure: every MCU byte is consumed; watchdog closes stalled frames.
module mcu_link_router #(
  parameter int          N_TGT       = 4,
  parameter int          TIMEOUT_CYC = 65535,
  parameter logic [7:0]  CFG_ID      = 8'hFE
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_strobe,
  input  logic                 in_start,
  input  logic [7:0]           in_data,
  output logic [7:0]           out_data,
  output logic [N_TGT-1:0]     tgt_strobe,
  output logic [N_TGT-1:0]     tgt_start,
  output logic [7:0]           tgt_data,
  input  logic [8*N_TGT-1:0]   tgt_dout,
  input  logic [N_TGT-1:0]     tgt_int,
  output logic                 int_out_n,
  output logic                 frame_active,
  output logic                 timeout_evt,
  output logic [7:0]           err_cnt
);

  localparam int SEL_W = (N_TGT > 1) ? $clog2(N_TGT) : 1;
  localparam int WD_W  = $clog2(TIMEOUT_CYC);

  typedef enum logic [2:0] {IDLE, HDR, ROUTE, CFG, DISCARD} state_t;

  state_t             state, state_nxt;
  logic [SEL_W-1:0]   sel, sel_nxt;
  logic [WD_W-1:0]    wd_cnt, wd_nxt;
  logic [7:0]         err_nxt;
  logic [N_TGT-1:0]   int_en, int_en_nxt;
  logic               cfg_done, cfg_done_nxt;
  logic               expire;

  logic [N_TGT-1:0]   strobe_nxt, start_nxt;
  logic [7:0]         data_nxt, out_nxt;
  logic [7:0]         dout_arr [N_TGT];

  // Unpack the flat reply bus so the selected target can be indexed directly
  always_comb begin
    for (int k = 0; k < N_TGT; k++) dout_arr[k] = tgt_dout[8*k +: 8];
  end

  // Register all state and the precomputed outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      sel         <= '0;
      wd_cnt      <= '0;
      err_cnt     <= 8'h00;
      int_en      <= '1;
      cfg_done    <= 1'b0;
      out_data    <= 8'h00;
      tgt_strobe  <= '0;
      tgt_start   <= '0;
      tgt_data    <= 8'h00;
      timeout_evt <= 1'b0;
    end else begin
      state       <= state_nxt;
      sel         <= sel_nxt;
      wd_cnt      <= wd_nxt;
      err_cnt     <= err_nxt;
      int_en      <= int_en_nxt;
      cfg_done    <= cfg_done_nxt;
      out_data    <= out_nxt;
      tgt_strobe  <= strobe_nxt;
      tgt_start   <= start_nxt;
      tgt_data    <= data_nxt;
      timeout_evt <= expire;
    end
  end

  // Next-state: frame decode, config capture, error count and watchdog
  always_comb begin
    state_nxt    = state;
    sel_nxt      = sel;
    err_nxt      = err_cnt;
    int_en_nxt   = int_en;
    cfg_done_nxt = cfg_done;
    // A byte arriving on the expiry cycle takes priority over the abort
    expire       = !in_strobe && (state != IDLE) && (wd_cnt == WD_W'(TIMEOUT_CYC - 1));
    wd_nxt       = (in_strobe || state == IDLE || expire) ? '0 : wd_cnt + 1'b1;

    if (in_strobe && in_start) begin
      cfg_done_nxt = 1'b0;
      if (int'(in_data) < N_TGT) begin
        state_nxt = HDR;
        sel_nxt   = in_data[SEL_W-1:0];
      end else if (in_data == CFG_ID) begin
        state_nxt = CFG;
      end else begin
        state_nxt = DISCARD;
        if (err_cnt != 8'hFF) err_nxt = err_cnt + 8'd1;
      end
    end else if (in_strobe) begin
      case (state)
        HDR: state_nxt = ROUTE;
        CFG: begin
          if (!cfg_done) int_en_nxt = in_data[N_TGT-1:0];
          cfg_done_nxt = 1'b1;
        end
        default: ;
      endcase
    end else if (expire) begin
      state_nxt = IDLE;
    end
  end

  // Outputs: target strobe/data for payload bytes and the reply byte by state
  always_comb begin
    strobe_nxt = '0;
    start_nxt  = '0;
    data_nxt   = 8'h00;
    if (in_strobe && !in_start && (state == HDR || state == ROUTE)) begin
      for (int k = 0; k < N_TGT; k++) strobe_nxt[k] = (sel == SEL_W'(k));
      start_nxt = (state == HDR) ? strobe_nxt : '0;
      data_nxt  = in_data;
    end
    case (state)
      HDR, CFG: out_nxt = 8'(tgt_int & int_en);
      ROUTE:    out_nxt = dout_arr[sel];
      DISCARD:  out_nxt = 8'hFF;
      default:  out_nxt = 8'h00;
    endcase
  end

  assign int_out_n    = ~|(tgt_int & int_en);
  assign frame_active = (state != IDLE);

endmodule

// File: tb/tb_mcu_link_router.sv
// Directed bench for mcu_link_router with N_TGT=4 and a short watchdog.
// Bytes are driven on the falling edge and registered outputs checked on the next falling edge.
// Summary line reports comparisons and failures.
module tb_mcu_link_router;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_strobe, in_start;
  logic [7:0]  in_data;
  logic [7:0]  out_data;
  logic [3:0]  tgt_strobe, tgt_start;
  logic [7:0]  tgt_data;
  logic [31:0] tgt_dout;
  logic [3:0]  tgt_int;
  logic        int_out_n, frame_active, timeout_evt;
  logic [7:0]  err_cnt;

  int checks = 0;
  int errors = 0;
  int evt_seen;
  int t0_strobes;

  mcu_link_router #(.N_TGT(4), .TIMEOUT_CYC(16), .CFG_ID(8'hFE)) dut (
    .clk(clk), .reset(reset),
    .in_strobe(in_strobe), .in_start(in_start), .in_data(in_data),
    .out_data(out_data),
    .tgt_strobe(tgt_strobe), .tgt_start(tgt_start), .tgt_data(tgt_data),
    .tgt_dout(tgt_dout), .tgt_int(tgt_int),
    .int_out_n(int_out_n), .frame_active(frame_active),
    .timeout_evt(timeout_evt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one byte for one cycle; returns at the falling edge after it was registered
  task automatic send(input logic st, input logic [7:0] d);
    @(negedge clk);
    in_strobe = 1'b1;
    in_start  = st;
    in_data   = d;
    @(negedge clk);
    in_strobe = 1'b0;
    in_start  = 1'b0;
    in_data   = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; in_strobe = 1'b0; in_start = 1'b0; in_data = 8'h00;
    tgt_dout = {8'h44, 8'h33, 8'h3C, 8'h11};
    tgt_int  = 4'b0000;
    idle(3);

    // Reset state
    check("rst_out_data", out_data, 8'h00);
    check("rst_strobe", tgt_strobe, 4'b0000);
    check("rst_start", tgt_start, 4'b0000);
    check("rst_tgt_data", tgt_data, 8'h00);
    check("rst_evt", timeout_evt, 1'b0);
    check("rst_active", frame_active, 1'b0);
    check("rst_err", err_cnt, 8'h00);
    check("rst_int_idle", int_out_n, 1'b1);
    tgt_int = 4'b1000;
    #1 check("rst_int_en_ones", int_out_n, 1'b0);
    tgt_int = 4'b0000;
    reset = 1'b0;
    idle(1);

    // Routed frame to target 1
    send(1'b1, 8'h01);
    check("hdr_no_strobe", tgt_strobe, 4'b0000);
    check("hdr_active", frame_active, 1'b1);
    send(1'b0, 8'h05);
    check("cmd_strobe", tgt_strobe, 4'b0010);
    check("cmd_start", tgt_start, 4'b0010);
    check("cmd_data", tgt_data, 8'h05);
    idle(1);
    check("route_reply", out_data, 8'h3C);
    check("pulse_clears", tgt_strobe, 4'b0000);
    send(1'b0, 8'hAA);
    check("aa_strobe", tgt_strobe, 4'b0010);
    check("aa_start", tgt_start, 4'b0000);
    check("aa_data", tgt_data, 8'hAA);
    send(1'b0, 8'h55);
    check("55_strobe", tgt_strobe, 4'b0010);
    check("55_data", tgt_data, 8'h55);

    // Unknown id -> discard
    send(1'b1, 8'h07);
    check("disc_err1", err_cnt, 8'd1);
    idle(1);
    check("disc_reply", out_data, 8'hFF);
    send(1'b0, 8'h12);
    check("disc_no_strobe", tgt_strobe, 4'b0000);
    for (int i = 0; i < 299; i++) send(1'b1, 8'h07);
    check("err_saturate", err_cnt, 8'hFF);

    // Interrupt enable via config frames
    tgt_int = 4'b0110;
    send(1'b1, 8'hFE);
    check("cfg_int_pre", int_out_n, 1'b0);
    idle(1);
    check("cfg_pending", out_data, 8'h06);
    send(1'b0, 8'h04);
    check("cfg_int_post", int_out_n, 1'b0);
    idle(1);
    check("cfg_pending_masked", out_data, 8'h04);
    send(1'b1, 8'hFE);
    send(1'b0, 8'h00);
    check("cfg_int_off", int_out_n, 1'b1);
    send(1'b1, 8'h02);
    idle(1);
    check("hdr_reply_masked", out_data, 8'h00);
    check("int_en_persists", int_out_n, 1'b1);
    send(1'b1, 8'hFE);
    send(1'b0, 8'h0F);
    send(1'b0, 8'h00);
    check("cfg_later_ignored", int_out_n, 1'b0);

    // Watchdog abort
    send(1'b1, 8'h02);
    send(1'b0, 8'h11);
    check("wd_strobe", tgt_strobe, 4'b0100);
    evt_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (timeout_evt) evt_seen++;
      if (tgt_strobe != 4'b0000) evt_seen += 100;
    end
    check("wd_evt_once", evt_seen, 1);
    check("wd_idle", frame_active, 1'b0);
    send(1'b0, 8'h33);
    check("wd_dropped", tgt_strobe, 4'b0000);

    // Back-to-back frames: restart mid-frame
    send(1'b1, 8'h00);
    send(1'b0, 8'h01);
    check("t0_start", tgt_start, 4'b0001);
    send(1'b0, 8'h02);
    check("t0_route", tgt_strobe, 4'b0001);
    t0_strobes = 0;
    send(1'b1, 8'h03);
    t0_strobes += int'(tgt_strobe[0]);
    send(1'b0, 8'h09);
    t0_strobes += int'(tgt_strobe[0]);
    check("t3_start", tgt_start, 4'b1000);
    check("t3_strobe", tgt_strobe, 4'b1000);
    check("t3_data", tgt_data, 8'h09);
    send(1'b0, 8'h0A);
    t0_strobes += int'(tgt_strobe[0]);
    check("t0_quiet", t0_strobes, 0);

    // Reset in the middle of a routed frame, coinciding with a byte
    send(1'b1, 8'hFE);
    send(1'b0, 8'h00);
    send(1'b1, 8'h01);
    send(1'b0, 8'h05);
    idle(1);
    check("pre_rst_int", int_out_n, 1'b1);
    @(negedge clk);
    reset = 1'b1; in_strobe = 1'b1; in_start = 1'b0; in_data = 8'hAA;
    @(negedge clk);
    in_strobe = 1'b0; in_data = 8'h00;
    check("mrst_strobe", tgt_strobe, 4'b0000);
    check("mrst_data", tgt_data, 8'h00);
    check("mrst_out", out_data, 8'h00);
    check("mrst_active", frame_active, 1'b0);
    check("mrst_err", err_cnt, 8'h00);
    check("mrst_int_en", int_out_n, 1'b0);
    reset = 1'b0;
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
